// File: rtl/patch_window_gate.sv
// patch_window_gate: follows the raster position of the camera pixel stream
// and, once armed by a request, forwards exactly the WIN x WIN pixels of the
// requested window to the patch buffer, then pulses o_done.
// Build option: define PATCH_CENTER_EN to treat i_x0/i_y0 as the window
// centre (clamped into the image) instead of the top-left origin.
module patch_window_gate #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 16,
  parameter int CW    = 10,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_start,
  input  logic          i_valid,
  input  logic [CW-1:0] i_R,
  input  logic [CW-1:0] i_G,
  input  logic [CW-1:0] i_B,
  input  logic          i_req,
  input  logic [XW-1:0] i_x0,
  input  logic [YW-1:0] i_y0,
  output logic [CW-1:0] o_R,
  output logic [CW-1:0] o_G,
  output logic [CW-1:0] o_B,
  output logic          o_take,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int CNT_W = 2 * $clog2(WIN);
  localparam logic [XW-1:0]    X_MAX    = XW'(IMG_W - WIN);
  localparam logic [YW-1:0]    Y_MAX    = YW'(IMG_H - WIN);
  localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_END    = YW'(IMG_H);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]    px, pos_x, x0_q, x0_req;
  logic [YW-1:0]    py, pos_y, y0_q, y0_req;
  logic             req_ok;
  logic [CNT_W-1:0] cnt;
  logic             done_pend;
  logic             in_win, live, take, last_take, abort, accept, reject;
  logic [CW-1:0]    r_p1, g_p1, b_p1;
  logic             vld_p1, done_p1, err_p1;

`ifdef PATCH_CENTER_EN
  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] c);
    logic signed [XW:0] t;
    t = $signed({1'b0, c}) - $signed((XW+1)'(WIN / 2));
    if (t[XW]) return '0;
    else if (t > $signed({1'b0, X_MAX})) return X_MAX;
    else return t[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] c);
    logic signed [YW:0] t;
    t = $signed({1'b0, c}) - $signed((YW+1)'(WIN / 2));
    if (t[YW]) return '0;
    else if (t > $signed({1'b0, Y_MAX})) return Y_MAX;
    else return t[YW-1:0];
  endfunction

  assign x0_req = clamp_x(i_x0);
  assign y0_req = clamp_y(i_y0);
  assign req_ok = 1'b1;
`else
  assign x0_req = i_x0;
  assign y0_req = i_y0;
  assign req_ok = (i_x0 <= X_MAX) && (i_y0 <= Y_MAX);
`endif

  // The pixel that arrives with i_frame_start is always (0,0).
  assign pos_x = i_frame_start ? '0 : px;
  assign pos_y = i_frame_start ? '0 : py;

  assign in_win = ({1'b0, pos_x} >= {1'b0, x0_q}) &&
                  ({1'b0, pos_x} <  {1'b0, x0_q} + (XW+1)'(WIN)) &&
                  ({1'b0, pos_y} >= {1'b0, y0_q}) &&
                  ({1'b0, pos_y} <  {1'b0, y0_q} + (YW+1)'(WIN)) &&
                  (pos_y != Y_END);

  // Capture is live in CAPTURE, and already on the arming frame_start pixel.
  assign live      = !done_pend &&
                     (((state == CAPTURE) && !i_frame_start) ||
                      ((state == ARMED) && i_frame_start));
  assign take      = live && i_valid && in_win;
  assign last_take = take && (cnt == CNT_LAST);
  assign abort     = (state == CAPTURE) && i_frame_start && !done_pend;
  assign accept    = (state == IDLE) && i_req && req_ok;
  assign reject    = (state == IDLE) && i_req && !req_ok;

  // Raster position: advance per valid pixel, saturate at line IMG_H.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      px <= '0;
      py <= '0;
    end else if (i_frame_start) begin
      px <= i_valid ? XW'(1) : '0;
      py <= '0;
    end else if (i_valid && (py != Y_END)) begin
      if (px == X_LAST) begin
        px <= '0;
        py <= py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  // Window origin latched when a request is accepted.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      x0_q <= x0_req;
      y0_q <= y0_req;
    end
  end

  // Taken-count; done_pend marks the cycle after the final take.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      done_pend <= 1'b0;
    end else begin
      done_pend <= last_take;
      if (abort || done_pend) cnt <= '0;
      else if (take)          cnt <= cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ARMED;
      ARMED:   if (i_frame_start) state_nxt = CAPTURE;
      CAPTURE: if (done_pend || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy until the o_done cycle.
  always_comb begin
    o_busy = (state != IDLE);
  end

  // ---- stage p1: registered pixel and status pulses ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      r_p1    <= '0;
      g_p1    <= '0;
      b_p1    <= '0;
    end else begin
      vld_p1  <= take;
      done_p1 <= done_pend;
      err_p1  <= reject || abort;
      if (take) begin
        r_p1 <= i_R;
        g_p1 <= i_G;
        b_p1 <= i_B;
      end
    end
  end

  assign o_R    = r_p1;
  assign o_G    = g_p1;
  assign o_B    = b_p1;
  assign o_take = vld_p1;
  assign o_done = done_p1;
  assign o_err  = err_p1;

endmodule
